// File: rtl/mod_feeder.sv
// Feeder stage: buffers {tag, data} words in a synchronous FIFO and replays each one
// for exactly one cycle as a registered enable/data pair for the downstream flip-flop.
module mod_feeder #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned BW    = TAG_W + DATA_W
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_valid,
    input  logic [BW-1:0] i_D,
    output logic          o_ready,
    input  logic          i_hold,
    input  logic          i_flush,
    output logic          o_E,
    output logic [BW-1:0] o_D,
    output logic [AW:0]   o_count,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_ovf
);

    logic [BW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          e_q, e_d;
    logic [BW-1:0] d_q, d_d;
    logic          ovf_q, ovf_d;
    logic          clear;
    logic          push;
    logic          pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == (AW + 1)'(DEPTH));
    assign o_ready = !o_full;
    assign clear   = i_rst || i_flush;
    assign push    = i_valid && o_ready && !clear;
    assign pop     = !i_hold && !o_empty && !clear;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        e_d     = 1'b0;
        d_d     = '0;
        ovf_d   = ovf_q;
        if (clear) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
                e_d    = 1'b1;
                d_d    = mem_q[rptr_q];
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
            // A word offered while full is dropped; remember that it happened.
            if (i_valid && o_full) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            e_q     <= 1'b0;
            d_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            e_q     <= e_d;
            d_q     <= d_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wptr_q] <= i_D;
        end
    end

    assign o_E     = e_q;
    assign o_D     = d_q;
    assign o_count = count_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_mod_feeder.sv
// Directed bench for mod_feeder: reset, latency, fill/overflow, wrap-around streaming,
// concurrent push/pop, and flush/reset clearing.
module tb_mod_feeder;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [11:0] din;
    logic        ready;
    logic        hold;
    logic        flush;
    logic        e;
    logic [11:0] dout;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    mod_feeder #(
        .DEPTH  (8),
        .TAG_W  (4),
        .DATA_W (8)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (valid),
        .i_D     (din),
        .o_ready (ready),
        .i_hold  (hold),
        .i_flush (flush),
        .o_E     (e),
        .o_D     (dout),
        .o_count (count),
        .o_empty (empty),
        .o_full  (full),
        .o_ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fill to full, overflow once, then pop three so count=5 with ovf set.
    task automatic prep_ovf5(input logic [7:0] base);
        hold  = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = {4'h5, base + 8'(i)};
            step();
        end
        din = {4'h5, base + 8'd8};
        step();
        valid = 1'b0;
        hold  = 1'b0;
        for (int i = 0; i < 3; i++) step();
        hold = 1'b1;
        chk("prep_count5", 32'(count), 32'd5);
        chk("prep_ovf", 32'(ovf), 32'd1);
    endtask

    // After a clear, nothing stale may surface and a fresh word must flow normally.
    task automatic post_clear_checks(input string pfx);
        chk({pfx, "_count"}, 32'(count), 32'd0);
        chk({pfx, "_E"}, 32'(e), 32'd0);
        chk({pfx, "_D"}, 32'(dout), 32'd0);
        chk({pfx, "_ovf"}, 32'(ovf), 32'd0);
        chk({pfx, "_empty"}, 32'(empty), 32'd1);
        chk({pfx, "_ready"}, 32'(ready), 32'd1);
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk({pfx, "_noStaleE"}, 32'(e), 32'd0);
        end
        valid = 1'b1;
        din   = 12'h660;
        step();
        valid = 1'b0;
        step();
        chk({pfx, "_freshE"}, 32'(e), 32'd1);
        chk({pfx, "_freshD"}, 32'(dout), 32'h660);
        step();
        chk({pfx, "_freshDoneE"}, 32'(e), 32'd0);
    endtask

    initial begin
        int in_idx;
        int out_idx;
        logic rdy;
        logic pushed;

        rst   = 1'b1;
        valid = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        din   = '0;
        step();
        step();
        rst = 1'b0;

        // Reset state held through idle cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_E", 32'(e), 32'd0);
            chk("idle_D", 32'(dout), 32'd0);
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_empty", 32'(empty), 32'd1);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_ovf", 32'(ovf), 32'd0);
        end

        // Three words, one-edge latency, presented once each
        valid = 1'b1;
        din   = 12'h111;
        step();
        chk("lat_E0", 32'(e), 32'd0);
        chk("lat_count1", 32'(count), 32'd1);
        din = 12'h222;
        step();
        chk("lat_E1", 32'(e), 32'd1);
        chk("lat_D1", 32'(dout), 32'h111);
        din = 12'h333;
        step();
        chk("lat_E2", 32'(e), 32'd1);
        chk("lat_D2", 32'(dout), 32'h222);
        valid = 1'b0;
        step();
        chk("lat_E3", 32'(e), 32'd1);
        chk("lat_D3", 32'(dout), 32'h333);
        step();
        chk("lat_E4", 32'(e), 32'd0);
        chk("lat_D4", 32'(dout), 32'd0);
        chk("lat_count0", 32'(count), 32'd0);

        // Fill under hold, overflow, then drain
        hold  = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            din = {4'h0, 8'(i)};
            step();
            chk("fill_count", 32'(count), 32'(i + 1));
            chk("fill_E", 32'(e), 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(ready), 32'd0);
        chk("fill_ovf_pre", 32'(ovf), 32'd0);
        din = 12'h008;
        step();
        chk("ovf_set", 32'(ovf), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        valid = 1'b0;
        hold  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_E", 32'(e), 32'd1);
            chk("drain_D", 32'(dout), 32'(i));
            chk("drain_ovf", 32'(ovf), 32'd1);
        end
        step();
        chk("drain_doneE", 32'(e), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Stream 20 words across the pointer wrap with hold toggling every 3 cycles
        in_idx  = 0;
        out_idx = 0;
        for (int cyc = 0; cyc < 200 && out_idx < 20; cyc++) begin
            hold = ((cyc / 3) % 2) == 1;
            if (in_idx < 20) begin
                valid = 1'b1;
                din   = {4'h2, 8'(in_idx)};
            end else begin
                valid = 1'b0;
            end
            rdy    = ready;
            pushed = valid && rdy;
            step();
            if (pushed) in_idx++;
            if (e) begin
                chk("wrap_D", 32'(dout), (out_idx < 20) ? 32'({4'h2, 8'(out_idx)}) : 32'hFFFF);
                out_idx++;
            end
            chk("wrap_cnt_le8", 32'(count <= 4'd8), 32'd1);
        end
        chk("wrap_all_out", 32'(out_idx), 32'd20);
        valid = 1'b0;
        hold  = 1'b0;
        step();
        chk("wrap_noDupE", 32'(e), 32'd0);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Concurrent push/pop at count=4
        hold  = 1'b1;
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = {4'h3, 8'h40 + 8'(i)};
            step();
        end
        chk("pp_count_pre", 32'(count), 32'd4);
        hold = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din = {4'h3, 8'h44 + 8'(i)};
            step();
            chk("pp_count", 32'(count), 32'd4);
            chk("pp_E", 32'(e), 32'd1);
            chk("pp_D", 32'(dout), 32'({4'h3, 8'h40 + 8'(i)}));
        end
        valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pp_tail_D", 32'(dout), 32'({4'h3, 8'h46 + 8'(i)}));
        end
        step();
        chk("pp_doneE", 32'(e), 32'd0);
        chk("pp_empty", 32'(empty), 32'd1);

        // Flush with a simultaneous push
        prep_ovf5(8'h70);
        flush = 1'b1;
        valid = 1'b1;
        din   = 12'h5EE;
        step();
        flush = 1'b0;
        valid = 1'b0;
        post_clear_checks("flush");

        // Same scenario cleared by reset instead
        prep_ovf5(8'h80);
        rst   = 1'b1;
        valid = 1'b1;
        din   = 12'h5DD;
        step();
        rst   = 1'b0;
        valid = 1'b0;
        post_clear_checks("rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
